ise_color_accum: RTL and testbench
==================================

Name: ise_color_accum

Overview:
- Front-end stage of the image sorting engine (ISE).
- Consumes the raw RGB pixel stream one image at a time and classifies each pixel by its dominant channel.
- Per image, accumulates pixel counts and the dominant-channel intensity sums.
- At image end, emits one record (image index, colour class, intensity sum, pixel count) to the downstream sorter, and back-pressures the pixel source while that record is being finalised or held.

Parameters:
PIX_PER_IMG  16384  pixels per image (128x128)
CNT_W        15     width of per-class pixel counters; must hold PIX_PER_IMG
SUM_W        22     width of per-class intensity sums; must hold 255*PIX_PER_IMG

Ports:
clk             in   1      system clock, all logic on rising edge
reset           in   1      synchronous, active-high
in_valid        in   1      pixel_in/image_in_index valid this cycle
image_in_index  in   5      image number of current pixel
pixel_in        in   24     R=[23:16], G=[15:8], B=[7:0]
busy            out  1      1 = pixel source must hold; pixel accepted only when in_valid && !busy
rec_valid       out  1      record valid
rec_ready       in   1      downstream accepts record
rec_index       out  5      image index of record
rec_color       out  2      00=red, 01=green, 10=blue (11 never produced)
rec_sum         out  SUM_W  sum of the winning channel over pixels of the winning class
rec_count       out  CNT_W  number of pixels of the winning class
idx_err         out  1      sticky: image_in_index changed mid-image

Behaviour:
- Reset: all outputs 0; FSM = ACCUM; pixel counter, class counters and sums cleared; idx_err cleared. Reset in any state aborts the partial image and any pending record.
- Pixel class: channel with the maximum value. Ties resolve R > G > B (e.g. R=G=200, B=10 -> red; G=B=90, R=0 -> green).
- On each accepted pixel:
  - Increment that class's counter.
  - Add that class's channel value to that class's sum; zero-extend, no saturation needed within parameter limits.
  - Increment the pixel counter.
- The first pixel of an image latches image_in_index into the index register.
- A later pixel of the same image whose index differs sets idx_err. That pixel is still accumulated into the current image; the latched index is kept.
- FSM states:
  - ACCUM: busy=0. When the pixel that makes pixel counter == PIX_PER_IMG is accepted at edge E, go to FINAL. busy is 1 in the cycle after E.
  - FINAL: one cycle, busy=1.
    - Winning class = largest counter; ties resolve R > G > B.
    - At the next edge (E+1), register rec_*, set rec_valid=1, clear all counters and sums, and go to HOLD.
  - HOLD: busy=1, rec_valid=1, rec_* stable.
    - On an edge with rec_ready=1, rec_valid drops to 0 and the FSM goes to ACCUM; busy=0 from that edge.
    - rec_ready may already be high when entering HOLD; minimum HOLD duration is 1 cycle.
- Latency:
  - Last pixel sampled at edge E -> rec_valid high after E+1.
  - Minimum dead time between images is 2 cycles (FINAL plus one HOLD cycle).
- rec_* hold their last values when rec_valid=0.
- in_valid while busy=1: ignored, no state change. in_valid=0 in ACCUM: no change. Inputs may be X/Z when in_valid=0.
- Images are processed strictly in arrival order; no buffering beyond one record.

Test Plan:
1. PIX_PER_IMG=4, index 3, pixels FF0000,800000,00FF00,0000FF -> rec_index=3, rec_color=00, rec_count=2, rec_sum=0x17F. busy high exactly 2 cycles with rec_ready tied 1.
2. Tie rules, PIX_PER_IMG=4, pixels C8C80A, 005A5A, 0000FF, 0000FF -> classes red, green, blue, blue -> rec_color=10, rec_count=2, rec_sum=0x1FE. Then pixels 010100 (red), 000101 (green), 000000 (red), 000001 (blue) -> red wins 2/1/1, rec_sum=0x01.
3. Backpressure: rec_ready=0 for 10 cycles after rec_valid -> busy=1 and rec_* stable throughout. Pixels offered during that time are not accepted and must be reissued. After rec_ready, the next image accumulates correctly from zero.
4. Default parameters, index 17, 16384 pixels of 00FF00 driven back-to-back -> rec_color=01, rec_count=16384, rec_sum=4177920. No counter overflow.
5. Index change mid-image (index 2 then 5 at pixel 2) -> idx_err=1 and stays 1, rec_index=2. A reset then clears idx_err.
6. Reset asserted mid-image and again in HOLD -> all outputs 0 next cycle. The following full image produces a correct record unaffected by the aborted data.

Source files
------------

// File: rtl/ise_color_accum.sv
`default_nettype none
// ============================================================================
//  Module   : ise_color_accum
//  Purpose  : Front-end stage of the image sorting engine. Classifies each
//             pixel of an image by its dominant colour channel and keeps
//             per-class pixel counts and intensity sums. At image end it
//             emits one record for the winning class and holds the pixel
//             source off until the record has been handed downstream.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             in_valid              - pixel_in / image_in_index valid
//             image_in_index [4:0]  - image number of the current pixel
//             pixel_in [23:0]       - R=[23:16], G=[15:8], B=[7:0]
//             busy                  - source must hold; accept = in_valid && !busy
//             rec_valid/rec_ready   - record handshake
//             rec_index/color/sum/count - record payload (held when idle)
//             idx_err               - sticky: index changed within an image
//  Revision : 1.0 - initial release
// ============================================================================
module ise_color_accum #(
  parameter int PIX_PER_IMG = 16384,
  parameter int CNT_W       = 15,
  parameter int SUM_W       = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [4:0]       image_in_index,
  input  logic [23:0]      pixel_in,
  output logic             busy,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [4:0]       rec_index,
  output logic [1:0]       rec_color,
  output logic [SUM_W-1:0] rec_sum,
  output logic [CNT_W-1:0] rec_count,
  output logic             idx_err
);

  localparam logic [1:0]       CLS_RED   = 2'd0;
  localparam logic [1:0]       CLS_GREEN = 2'd1;
  localparam logic [1:0]       CLS_BLUE  = 2'd2;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PIX_PER_IMG - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FINAL = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b;
  logic [SUM_W-1:0] sum_r, sum_g, sum_b;
  logic [4:0]       idx_reg;

  logic [7:0]       ch_r, ch_g, ch_b;
  logic [1:0]       pix_class;
  logic [SUM_W-1:0] pix_val;
  logic             accept;
  logic             last_pix;
  logic [1:0]       win_class;
  logic [CNT_W-1:0] win_cnt;
  logic [SUM_W-1:0] win_sum;

  assign ch_r = pixel_in[23:16];
  assign ch_g = pixel_in[15:8];
  assign ch_b = pixel_in[7:0];

  assign accept   = in_valid && (state == ST_ACCUM);
  assign last_pix = accept && (pix_cnt == LAST_CNT);

  assign busy      = (state != ST_ACCUM);
  assign rec_valid = (state == ST_HOLD);

  // Dominant channel; the >= comparisons give ties to red, then green.
  always_comb begin
    pix_class = CLS_BLUE;
    pix_val   = {{(SUM_W-8){1'b0}}, ch_b};
    if ((ch_r >= ch_g) && (ch_r >= ch_b)) begin
      pix_class = CLS_RED;
      pix_val   = {{(SUM_W-8){1'b0}}, ch_r};
    end else if (ch_g >= ch_b) begin
      pix_class = CLS_GREEN;
      pix_val   = {{(SUM_W-8){1'b0}}, ch_g};
    end
  end

  // Winning class by pixel count, same red > green > blue tie order.
  always_comb begin
    win_class = CLS_BLUE;
    win_cnt   = cnt_b;
    win_sum   = sum_b;
    if ((cnt_r >= cnt_g) && (cnt_r >= cnt_b)) begin
      win_class = CLS_RED;
      win_cnt   = cnt_r;
      win_sum   = sum_r;
    end else if (cnt_g >= cnt_b) begin
      win_class = CLS_GREEN;
      win_cnt   = cnt_g;
      win_sum   = sum_g;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM: if (last_pix)  state_nxt = ST_FINAL;
      ST_FINAL:                state_nxt = ST_HOLD;
      ST_HOLD:  if (rec_ready) state_nxt = ST_ACCUM;
      default:                 state_nxt = ST_ACCUM;
    endcase
  end

  // Accumulators, index tracking and record registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt   <= '0;
      cnt_r     <= '0;
      cnt_g     <= '0;
      cnt_b     <= '0;
      sum_r     <= '0;
      sum_g     <= '0;
      sum_b     <= '0;
      idx_reg   <= '0;
      idx_err   <= 1'b0;
      rec_index <= '0;
      rec_color <= '0;
      rec_sum   <= '0;
      rec_count <= '0;
    end else begin
      if (accept) begin
        pix_cnt <= pix_cnt + CNT_ONE;
        case (pix_class)
          CLS_RED: begin
            cnt_r <= cnt_r + CNT_ONE;
            sum_r <= sum_r + pix_val;
          end
          CLS_GREEN: begin
            cnt_g <= cnt_g + CNT_ONE;
            sum_g <= sum_g + pix_val;
          end
          default: begin
            cnt_b <= cnt_b + CNT_ONE;
            sum_b <= sum_b + pix_val;
          end
        endcase
        // First pixel names the image; later mismatches are flagged but
        // the pixel still counts toward the current image.
        if (pix_cnt == '0) begin
          idx_reg <= image_in_index;
        end else if (image_in_index != idx_reg) begin
          idx_err <= 1'b1;
        end
      end

      if (state == ST_FINAL) begin
        rec_index <= idx_reg;
        rec_color <= win_class;
        rec_sum   <= win_sum;
        rec_count <= win_cnt;
        pix_cnt   <= '0;
        cnt_r     <= '0;
        cnt_g     <= '0;
        cnt_b     <= '0;
        sum_r     <= '0;
        sum_g     <= '0;
        sum_b     <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ise_color_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ise_color_accum
//  Purpose  : Directed self-checking bench for ise_color_accum. Instance "a"
//             uses a 4-pixel image for the functional scenarios; instance
//             "b" uses the default 128x128 image size.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ise_color_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_valid, a_busy, a_rec_valid, a_rec_ready, a_idx_err;
  logic [4:0]  a_idx, a_rec_index;
  logic [23:0] a_pix;
  logic [1:0]  a_rec_color;
  logic [21:0] a_rec_sum;
  logic [14:0] a_rec_count;

  logic        b_valid, b_busy, b_rec_valid, b_rec_ready, b_idx_err;
  logic [4:0]  b_idx, b_rec_index;
  logic [23:0] b_pix;
  logic [1:0]  b_rec_color;
  logic [21:0] b_rec_sum;
  logic [14:0] b_rec_count;

  int errors = 0;
  int checks = 0;

  ise_color_accum #(.PIX_PER_IMG(4), .CNT_W(15), .SUM_W(22)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .image_in_index(a_idx),
    .pixel_in(a_pix), .busy(a_busy), .rec_valid(a_rec_valid),
    .rec_ready(a_rec_ready), .rec_index(a_rec_index), .rec_color(a_rec_color),
    .rec_sum(a_rec_sum), .rec_count(a_rec_count), .idx_err(a_idx_err)
  );

  ise_color_accum dut_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .image_in_index(b_idx),
    .pixel_in(b_pix), .busy(b_busy), .rec_valid(b_rec_valid),
    .rec_ready(b_rec_ready), .rec_index(b_rec_index), .rec_color(b_rec_color),
    .rec_sum(b_rec_sum), .rec_count(b_rec_count), .idx_err(b_idx_err)
  );

  // Offer one pixel to instance a and hold it until an edge with busy=0.
  task automatic send_a(input logic [4:0] idx, input logic [23:0] pix);
    int guard = 0;
    a_valid = 1'b1;
    a_idx   = idx;
    a_pix   = pix;
    while (a_busy && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout busy=%b required 0", a_busy);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_idx   = 'x;
    a_pix   = 'x;
  endtask

  // Wait (bounded) for instance a to present a record.
  task automatic wait_rec_a();
    int guard = 0;
    while (!a_rec_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      checks++; errors++;
      $display("FAIL rec_timeout rec_valid=%b required 1", a_rec_valid);
    end
  endtask

  // Wait (bounded) for instance a to return to accumulation.
  task automatic wait_idle_a();
    int guard = 0;
    while (a_busy && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      checks++; errors++;
      $display("FAIL idle_timeout busy=%b required 0", a_busy);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    a_valid = 1'b0; a_idx = '0; a_pix = '0; a_rec_ready = 1'b1;
    b_valid = 1'b0; b_idx = '0; b_pix = '0; b_rec_ready = 1'b1;
    pulse_reset();
    checks++;
    if ({a_busy, a_rec_valid, a_rec_index, a_rec_color, a_rec_sum, a_rec_count, a_idx_err} !== '0) begin
      errors++;
      $display("FAIL reset_a busy=%b rv=%b idx=%0d col=%0d sum=%0h cnt=%0d err=%b required all 0",
               a_busy, a_rec_valid, a_rec_index, a_rec_color, a_rec_sum, a_rec_count, a_idx_err);
    end
    checks++;
    if ({b_busy, b_rec_valid, b_rec_index, b_rec_color, b_rec_sum, b_rec_count, b_idx_err} !== '0) begin
      errors++;
      $display("FAIL reset_b busy=%b rv=%b idx=%0d col=%0d sum=%0h cnt=%0d err=%b required all 0",
               b_busy, b_rec_valid, b_rec_index, b_rec_color, b_rec_sum, b_rec_count, b_idx_err);
    end
  endtask

  task automatic test_basic();
    int busy_cyc = 0;
    logic seen = 1'b0;
    logic [4:0]  g_idx = '0;
    logic [1:0]  g_col = '0;
    logic [21:0] g_sum = '0;
    logic [14:0] g_cnt = '0;
    a_rec_ready = 1'b1;
    send_a(5'd3, 24'hFF0000);
    send_a(5'd3, 24'h800000);
    send_a(5'd3, 24'h00FF00);
    send_a(5'd3, 24'h0000FF);
    // Now one cycle past the edge that took the last pixel.
    checks++;
    if (a_rec_valid !== 1'b0) begin
      errors++; $display("FAIL basic_latency_early rec_valid=%b required 0", a_rec_valid);
    end
    while (a_busy && busy_cyc < 10) begin
      if (a_rec_valid && !seen) begin
        seen = 1'b1;
        g_idx = a_rec_index; g_col = a_rec_color; g_sum = a_rec_sum; g_cnt = a_rec_count;
      end
      @(posedge clk); #1;
      busy_cyc++;
    end
    checks++;
    if (busy_cyc !== 2) begin
      errors++; $display("FAIL basic_busy_cycles got=%0d required 2", busy_cyc);
    end
    checks++;
    if ({seen, g_idx, g_col, g_sum, g_cnt} !== {1'b1, 5'd3, 2'd0, 22'h17F, 15'd2}) begin
      errors++;
      $display("FAIL basic_record seen=%b idx=%0d col=%0d sum=%0h cnt=%0d required 1 3 0 17f 2",
               seen, g_idx, g_col, g_sum, g_cnt);
    end
    checks++;
    if ({a_rec_valid, a_rec_index, a_rec_color, a_rec_sum, a_rec_count} !==
        {1'b0, 5'd3, 2'd0, 22'h17F, 15'd2}) begin
      errors++;
      $display("FAIL basic_hold_after rv=%b idx=%0d col=%0d sum=%0h cnt=%0d required 0 3 0 17f 2",
               a_rec_valid, a_rec_index, a_rec_color, a_rec_sum, a_rec_count);
    end
  endtask

  task automatic test_ties();
    a_rec_ready = 1'b1;
    send_a(5'd4, 24'hC8C80A);
    send_a(5'd4, 24'h005A5A);
    send_a(5'd4, 24'h0000FF);
    send_a(5'd4, 24'h0000FF);
    wait_rec_a();
    checks++;
    if ({a_rec_index, a_rec_color, a_rec_sum, a_rec_count} !== {5'd4, 2'd2, 22'h1FE, 15'd2}) begin
      errors++;
      $display("FAIL ties_blue idx=%0d col=%0d sum=%0h cnt=%0d required 4 2 1fe 2",
               a_rec_index, a_rec_color, a_rec_sum, a_rec_count);
    end
    wait_idle_a();
    send_a(5'd5, 24'h010100);
    send_a(5'd5, 24'h000101);
    send_a(5'd5, 24'h000000);
    send_a(5'd5, 24'h000001);
    wait_rec_a();
    checks++;
    if ({a_rec_index, a_rec_color, a_rec_sum, a_rec_count} !== {5'd5, 2'd0, 22'h001, 15'd2}) begin
      errors++;
      $display("FAIL ties_red idx=%0d col=%0d sum=%0h cnt=%0d required 5 0 1 2",
               a_rec_index, a_rec_color, a_rec_sum, a_rec_count);
    end
    wait_idle_a();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    a_rec_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(5'd7, 24'h00FF00);
    wait_rec_a();
    checks++;
    if ({a_rec_index, a_rec_color, a_rec_sum, a_rec_count} !== {5'd7, 2'd1, 22'h3FC, 15'd4}) begin
      errors++;
      $display("FAIL bp_record idx=%0d col=%0d sum=%0h cnt=%0d required 7 1 3fc 4",
               a_rec_index, a_rec_color, a_rec_sum, a_rec_count);
    end
    // Offer pixels that must be ignored while the record is held.
    a_valid = 1'b1; a_idx = 5'd9; a_pix = 24'hFF0000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ({a_busy, a_rec_valid, a_rec_index, a_rec_color, a_rec_sum, a_rec_count} !==
          {1'b1, 1'b1, 5'd7, 2'd1, 22'h3FC, 15'd4}) bad++;
    end
    a_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL bp_stable unstable_cycles=%0d required 0", bad);
    end
    a_rec_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({a_busy, a_rec_valid} !== 2'b00) begin
      errors++; $display("FAIL bp_release busy=%b rv=%b required 0 0", a_busy, a_rec_valid);
    end
    for (int i = 0; i < 4; i++) send_a(5'd8, 24'h000080);
    wait_rec_a();
    checks++;
    if ({a_rec_index, a_rec_color, a_rec_sum, a_rec_count} !== {5'd8, 2'd2, 22'h200, 15'd4}) begin
      errors++;
      $display("FAIL bp_next_image idx=%0d col=%0d sum=%0h cnt=%0d required 8 2 200 4",
               a_rec_index, a_rec_color, a_rec_sum, a_rec_count);
    end
    wait_idle_a();
  endtask

  task automatic test_idx_err();
    a_rec_ready = 1'b1;
    send_a(5'd2, 24'h010000);
    send_a(5'd2, 24'h010000);
    checks++;
    if (a_idx_err !== 1'b0) begin
      errors++; $display("FAIL idx_err_early got=%b required 0", a_idx_err);
    end
    send_a(5'd5, 24'h010000);
    checks++;
    if (a_idx_err !== 1'b1) begin
      errors++; $display("FAIL idx_err_set got=%b required 1", a_idx_err);
    end
    send_a(5'd5, 24'h010000);
    wait_rec_a();
    checks++;
    if ({a_rec_index, a_rec_color, a_rec_sum, a_rec_count} !== {5'd2, 2'd0, 22'h004, 15'd4}) begin
      errors++;
      $display("FAIL idx_err_record idx=%0d col=%0d sum=%0h cnt=%0d required 2 0 4 4",
               a_rec_index, a_rec_color, a_rec_sum, a_rec_count);
    end
    wait_idle_a();
    checks++;
    if (a_idx_err !== 1'b1) begin
      errors++; $display("FAIL idx_err_sticky got=%b required 1", a_idx_err);
    end
    pulse_reset();
    checks++;
    if (a_idx_err !== 1'b0) begin
      errors++; $display("FAIL idx_err_clear got=%b required 0", a_idx_err);
    end
  endtask

  task automatic test_reset_abort();
    a_rec_ready = 1'b1;
    send_a(5'd1, 24'hFF0000);
    send_a(5'd1, 24'hFF0000);
    pulse_reset();
    checks++;
    if ({a_busy, a_rec_valid, a_rec_index, a_rec_color, a_rec_sum, a_rec_count, a_idx_err} !== '0) begin
      errors++; $display("FAIL abort_mid_outputs busy=%b rv=%b cnt=%0d required all 0",
                         a_busy, a_rec_valid, a_rec_count);
    end
    send_a(5'd4, 24'h0000FF);
    send_a(5'd4, 24'h0000FF);
    send_a(5'd4, 24'h0000FF);
    checks++;
    if (a_busy !== 1'b0) begin
      errors++; $display("FAIL abort_mid_stale_count busy=%b required 0", a_busy);
    end
    send_a(5'd4, 24'h00FF00);
    wait_rec_a();
    checks++;
    if ({a_rec_index, a_rec_color, a_rec_sum, a_rec_count, a_idx_err} !==
        {5'd4, 2'd2, 22'h2FD, 15'd3, 1'b0}) begin
      errors++;
      $display("FAIL abort_mid_record idx=%0d col=%0d sum=%0h cnt=%0d err=%b required 4 2 2fd 3 0",
               a_rec_index, a_rec_color, a_rec_sum, a_rec_count, a_idx_err);
    end
    wait_idle_a();
    a_rec_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(5'd6, 24'h800000);
    wait_rec_a();
    pulse_reset();
    checks++;
    if ({a_busy, a_rec_valid, a_rec_index, a_rec_color, a_rec_sum, a_rec_count, a_idx_err} !== '0) begin
      errors++;
      $display("FAIL abort_hold_outputs busy=%b rv=%b idx=%0d col=%0d sum=%0h cnt=%0d required all 0",
               a_busy, a_rec_valid, a_rec_index, a_rec_color, a_rec_sum, a_rec_count);
    end
    a_rec_ready = 1'b1;
    send_a(5'd10, 24'h00FF00);
    send_a(5'd10, 24'h00FF00);
    send_a(5'd10, 24'h00FF00);
    send_a(5'd10, 24'hFF0000);
    wait_rec_a();
    checks++;
    if ({a_rec_index, a_rec_color, a_rec_sum, a_rec_count} !== {5'd10, 2'd1, 22'h2FD, 15'd3}) begin
      errors++;
      $display("FAIL abort_hold_record idx=%0d col=%0d sum=%0h cnt=%0d required 10 1 2fd 3",
               a_rec_index, a_rec_color, a_rec_sum, a_rec_count);
    end
    wait_idle_a();
  endtask

  task automatic test_default_params();
    int guard = 0;
    b_rec_ready = 1'b1;
    b_valid = 1'b1; b_idx = 5'd17; b_pix = 24'h00FF00;
    checks++;
    if (b_busy !== 1'b0) begin
      errors++; $display("FAIL big_start busy=%b required 0", b_busy);
    end
    repeat (16384) begin
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    checks++;
    if ({b_busy, b_rec_valid} !== 2'b10) begin
      errors++; $display("FAIL big_final busy=%b rv=%b required 1 0", b_busy, b_rec_valid);
    end
    while (!b_rec_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (guard !== 1) begin
      errors++; $display("FAIL big_latency cycles=%0d required 1", guard);
    end
    checks++;
    if ({b_rec_index, b_rec_color, b_rec_sum, b_rec_count, b_idx_err} !==
        {5'd17, 2'd1, 22'd4177920, 15'd16384, 1'b0}) begin
      errors++;
      $display("FAIL big_record idx=%0d col=%0d sum=%0d cnt=%0d err=%b required 17 1 4177920 16384 0",
               b_rec_index, b_rec_color, b_rec_sum, b_rec_count, b_idx_err);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_idx_err();
    test_reset_abort();
    test_default_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
